mem_wb_elastic_reg: RTL and testbench
=====================================

MEM_WB_ELASTIC_REG -- requirements
Module: mem_wb_elastic_reg

Interface
REQ-001 Parameters SHALL be (name, default, meaning): XLEN, 32, data/PC width; RF_ADDR_W, 5, register-file address width; SKID_EN, 1, 1 = two-entry skid buffer, 0 = single-entry stage.
REQ-002 CLK  in  1  sole clock; all state updates on rising edge.
REQ-003 RST_N  in  1  asynchronous, active-low reset.
REQ-004 ValidM  in  1  MEM-stage payload valid.
REQ-005 ReadyM  out  1  stage can accept payload this cycle.
REQ-006 RegWriteM  in  1; ResultSrcM  in  2; ALUResultM  in  XLEN; ReadDataM  in  XLEN; RdM  in  RF_ADDR_W; PCPlus4M  in  XLEN: MEM-stage payload.
REQ-007 FlushW  in  1  synchronous squash of all held entries.
REQ-008 ReadyW  in  1  WB consumes head entry this cycle (0 = WB stall).
REQ-009 ValidW  out  1  head entry valid.
REQ-010 RegWriteW  out  1; ResultSrcW  out  2; ALUResultW  out  XLEN; ReadDataW  out  XLEN; RdW  out  RF_ADDR_W; PCPlus4W  out  XLEN: head payload.
REQ-011 Occupancy  out  2  entries held (0..2; max 1 when SKID_EN=0).
REQ-012 FlushCnt  out  8  saturating count of cycles with FlushW=1 that discarded at least one valid entry.

Function
REQ-013 Accept SHALL occur when ValidM && ReadyM; pop SHALL occur when ValidW && ReadyW.
REQ-014 SKID_EN=1: ReadyM SHALL be registered, equal to !skid_valid; no combinational path from ReadyW to ReadyM.
REQ-015 SKID_EN=0: ReadyM SHALL be !head_valid || ReadyW (combinational).
REQ-016 Latency SHALL be one cycle: payload accepted at edge N SHALL be visible on W outputs after edge N when the head was empty or popping at N.
REQ-017 Ordering SHALL be FIFO; skid entry SHALL move to head on the edge the head pops; the new accept goes to skid if skid moved or stays empty otherwise per REQ-018.
REQ-018 Accept with head full and no pop SHALL load skid; accept with head popping and skid empty SHALL load head; accept with head empty SHALL load head.
REQ-019 Simultaneous accept and pop with Occupancy=2 SHALL be impossible (ReadyM=0); with Occupancy=1 SHALL leave Occupancy=1 holding the new payload.
REQ-020 RegWriteW SHALL equal stored RegWrite && ValidW && (RdW != 0); x0 writes SHALL never be presented.
REQ-021 When ValidW=0, RegWriteW SHALL be 0; other payload outputs SHALL hold last head value (don't-care for WB).
REQ-022 Head payload SHALL be stable while ValidW && !ReadyW.
REQ-023 FlushW=1 SHALL clear head and skid valid at that edge, discard any same-cycle accept, and force ReadyM=1 in the following cycle; FlushW SHALL override accept and pop.
REQ-024 FlushCnt SHALL increment by 1 on a flush edge where Occupancy>0, and saturate at 255.
REQ-025 Occupancy SHALL equal head_valid + skid_valid, registered.

Reset
REQ-026 RST_N=0 SHALL immediately, independent of CLK, clear head_valid, skid_valid, all payload registers to 0, FlushCnt to 0; outputs ValidW=0, RegWriteW=0, Occupancy=0.
REQ-027 During reset ReadyM SHALL be 0 (SKID_EN=1) or 1 (SKID_EN=0); first accept SHALL be possible on the first edge after RST_N rises.
REQ-028 Reset asserted mid-transfer SHALL drop all held entries; no partial payload SHALL appear after release.

Verification
REQ-029 Stream: ReadyW=1, ValidM=1 for 4 cycles, RdM=1..4, ALUResultM=0x10..0x13 -> ValidW on cycles 1..4, RdW 1..4 in order, Occupancy=1 throughout.
REQ-030 Backpressure (SKID_EN=1): ReadyW=0, three accept attempts RdM=5,6,7 -> 5 head, 6 skid, ReadyM=0 on third, Occupancy=2; ReadyW=1 -> 5 then 6 then 7 delivered, none lost or duplicated.
REQ-031 x0 suppression: RegWriteM=1, RdM=0, ALUResultM=0xDEADBEEF -> ValidW=1, RegWriteW=0.
REQ-032 Flush: Occupancy=2, FlushW=1 with ValidM=1 -> next cycle ValidW=0, Occupancy=0, ReadyM=1, FlushCnt=1; flush with Occupancy=0 -> FlushCnt unchanged.
REQ-033 Async reset: RST_N low between edges while Occupancy=2 -> ValidW=0, Occupancy=0, FlushCnt=0 before next edge.
REQ-034 SKID_EN=0: ReadyW=0 with head full -> ReadyM=0; ReadyW=1 same cycle -> ReadyM=1, new payload in head next cycle; FlushCnt saturates at 255 after 300 non-empty flushes.

Source files
------------

// File: rtl/mem_wb_elastic_reg.sv
// MEM->WB pipeline register with optional two-entry skid buffer.
// Head drives the W outputs; skid catches one extra payload while WB stalls.
module mem_wb_elastic_reg #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5,
  parameter bit SKID_EN   = 1'b1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 ValidM,
  output logic                 ReadyM,
  input  logic                 RegWriteM,
  input  logic [1:0]           ResultSrcM,
  input  logic [XLEN-1:0]      ALUResultM,
  input  logic [XLEN-1:0]      ReadDataM,
  input  logic [RF_ADDR_W-1:0] RdM,
  input  logic [XLEN-1:0]      PCPlus4M,
  input  logic                 FlushW,
  input  logic                 ReadyW,
  output logic                 ValidW,
  output logic                 RegWriteW,
  output logic [1:0]           ResultSrcW,
  output logic [XLEN-1:0]      ALUResultW,
  output logic [XLEN-1:0]      ReadDataW,
  output logic [RF_ADDR_W-1:0] RdW,
  output logic [XLEN-1:0]      PCPlus4W,
  output logic [1:0]           Occupancy,
  output logic [7:0]           FlushCnt
);

  typedef struct packed {
    logic                 reg_write;
    logic [1:0]           result_src;
    logic [XLEN-1:0]      alu_result;
    logic [XLEN-1:0]      read_data;
    logic [RF_ADDR_W-1:0] rd;
    logic [XLEN-1:0]      pc_plus4;
  } payload_t;

  payload_t   in_pl, head, skid;
  logic       head_v, skid_v;
  logic [7:0] flush_cnt;
  logic       acc, pop;

  assign in_pl = '{reg_write:  RegWriteM,
                   result_src: ResultSrcM,
                   alu_result: ALUResultM,
                   read_data:  ReadDataM,
                   rd:         RdM,
                   pc_plus4:   PCPlus4M};

  assign acc = ValidM & ReadyM;
  assign pop = head_v & ReadyW;

  generate
    if (SKID_EN) begin : g_skid_rdy
      // Depends only on the skid flop; RST_N gating holds it low during reset
      // yet lets the first edge after release accept.
      assign ReadyM = RST_N & ~skid_v;
    end else begin : g_pass_rdy
      assign ReadyM = ~head_v | ReadyW;
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      head_v    <= 1'b0;
      skid_v    <= 1'b0;
      head      <= '0;
      skid      <= '0;
      flush_cnt <= '0;
    end else if (FlushW) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      if ((head_v || skid_v) && flush_cnt != 8'hFF)
        flush_cnt <= flush_cnt + 8'd1;
    end else if (!head_v || pop) begin
      // Head is free this edge: older skid entry wins over a new accept.
      if (skid_v) begin
        head   <= skid;
        head_v <= 1'b1;
        skid_v <= acc;
        if (acc) skid <= in_pl;
      end else begin
        head_v <= acc;
        if (acc) head <= in_pl;
      end
    end else if (acc && SKID_EN) begin
      skid   <= in_pl;
      skid_v <= 1'b1;
    end
  end

  assign ValidW     = head_v;
  assign RegWriteW  = head.reg_write & head_v & (head.rd != '0);
  assign ResultSrcW = head.result_src;
  assign ALUResultW = head.alu_result;
  assign ReadDataW  = head.read_data;
  assign RdW        = head.rd;
  assign PCPlus4W   = head.pc_plus4;
  assign Occupancy  = {1'b0, head_v} + {1'b0, skid_v};
  assign FlushCnt   = flush_cnt;

endmodule

// File: tb/tb_mem_wb_elastic_reg.sv
// Directed bench: instance a has the skid buffer, instance b is single-entry.
module tb_mem_wb_elastic_reg;
  logic clk = 1'b0;
  logic RST_N;
  always #5 clk = ~clk;

  logic        a_ValidM, a_ReadyM, a_RegWriteM, a_FlushW, a_ReadyW, a_ValidW, a_RegWriteW;
  logic [1:0]  a_ResultSrcM, a_ResultSrcW, a_Occupancy;
  logic [31:0] a_ALUResultM, a_ReadDataM, a_PCPlus4M, a_ALUResultW, a_ReadDataW, a_PCPlus4W;
  logic [4:0]  a_RdM, a_RdW;
  logic [7:0]  a_FlushCnt;

  logic        b_ValidM, b_ReadyM, b_RegWriteM, b_FlushW, b_ReadyW, b_ValidW, b_RegWriteW;
  logic [1:0]  b_ResultSrcM, b_ResultSrcW, b_Occupancy;
  logic [31:0] b_ALUResultM, b_ReadDataM, b_PCPlus4M, b_ALUResultW, b_ReadDataW, b_PCPlus4W;
  logic [4:0]  b_RdM, b_RdW;
  logic [7:0]  b_FlushCnt;

  int checks = 0;
  int errors = 0;

  mem_wb_elastic_reg #(.XLEN(32), .RF_ADDR_W(5), .SKID_EN(1'b1)) dut_a (
    .CLK(clk), .RST_N(RST_N), .ValidM(a_ValidM), .ReadyM(a_ReadyM),
    .RegWriteM(a_RegWriteM), .ResultSrcM(a_ResultSrcM), .ALUResultM(a_ALUResultM),
    .ReadDataM(a_ReadDataM), .RdM(a_RdM), .PCPlus4M(a_PCPlus4M),
    .FlushW(a_FlushW), .ReadyW(a_ReadyW), .ValidW(a_ValidW), .RegWriteW(a_RegWriteW),
    .ResultSrcW(a_ResultSrcW), .ALUResultW(a_ALUResultW), .ReadDataW(a_ReadDataW),
    .RdW(a_RdW), .PCPlus4W(a_PCPlus4W), .Occupancy(a_Occupancy), .FlushCnt(a_FlushCnt));

  mem_wb_elastic_reg #(.XLEN(32), .RF_ADDR_W(5), .SKID_EN(1'b0)) dut_b (
    .CLK(clk), .RST_N(RST_N), .ValidM(b_ValidM), .ReadyM(b_ReadyM),
    .RegWriteM(b_RegWriteM), .ResultSrcM(b_ResultSrcM), .ALUResultM(b_ALUResultM),
    .ReadDataM(b_ReadDataM), .RdM(b_RdM), .PCPlus4M(b_PCPlus4M),
    .FlushW(b_FlushW), .ReadyW(b_ReadyW), .ValidW(b_ValidW), .RegWriteW(b_RegWriteW),
    .ResultSrcW(b_ResultSrcW), .ALUResultW(b_ALUResultW), .ReadDataW(b_ReadDataW),
    .RdW(b_RdW), .PCPlus4W(b_PCPlus4W), .Occupancy(b_Occupancy), .FlushCnt(b_FlushCnt));

  // Advance one rising edge; outputs are sampled 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_drive(input logic v, input logic [4:0] rd, input logic [31:0] alu);
    a_ValidM = v; a_RdM = rd; a_ALUResultM = alu; a_RegWriteM = 1'b1;
    a_ResultSrcM = 2'd1; a_ReadDataM = alu ^ 32'hFFFF_0000; a_PCPlus4M = {27'd0, rd} << 2;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    a_drive(1'b0, 5'd0, 32'd0); a_FlushW = 1'b0; a_ReadyW = 1'b0;
    b_ValidM = 1'b0; b_RdM = '0; b_ALUResultM = '0; b_RegWriteM = 1'b0; b_ResultSrcM = '0;
    b_ReadDataM = '0; b_PCPlus4M = '0; b_FlushW = 1'b0; b_ReadyW = 1'b0;
    step(); step();
    checks++; if (a_ValidW !== 1'b0) begin errors++; $display("FAIL rst_validw got %0b want 0", a_ValidW); end
    checks++; if (a_Occupancy !== 2'd0) begin errors++; $display("FAIL rst_occ got %0d want 0", a_Occupancy); end
    checks++; if (a_ReadyM !== 1'b0) begin errors++; $display("FAIL rst_readym_skid got %0b want 0", a_ReadyM); end
    checks++; if (b_ReadyM !== 1'b1) begin errors++; $display("FAIL rst_readym_noskid got %0b want 1", b_ReadyM); end
    checks++; if (a_FlushCnt !== 8'd0) begin errors++; $display("FAIL rst_flushcnt got %0d want 0", a_FlushCnt); end
    checks++; if (a_ALUResultW !== 32'd0) begin errors++; $display("FAIL rst_alu got %0h want 0", a_ALUResultW); end
    #3 RST_N = 1'b1; #1;
    checks++; if (a_ReadyM !== 1'b1) begin errors++; $display("FAIL rel_readym got %0b want 1", a_ReadyM); end
  endtask

  task automatic test_stream();
    a_ReadyW = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_drive(1'b1, 5'(i + 1), 32'h10 + 32'(i));
      step();
      checks++; if (a_ValidW !== 1'b1 || a_RdW !== 5'(i + 1) || a_ALUResultW !== 32'h10 + 32'(i))
        begin errors++; $display("FAIL stream_%0d got v=%0b rd=%0d alu=%0h want v=1 rd=%0d alu=%0h",
          i, a_ValidW, a_RdW, a_ALUResultW, i + 1, 32'h10 + i); end
      checks++; if (a_Occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ_%0d got %0d want 1", i, a_Occupancy); end
    end
    checks++; if (a_PCPlus4W !== 32'd16 || a_ReadDataW !== 32'hFFFF_0013) begin errors++;
      $display("FAIL stream_payload got pc=%0h rdata=%0h want 10 ffff0013", a_PCPlus4W, a_ReadDataW); end
    a_drive(1'b0, 5'd0, 32'd0);
    step();
    checks++; if (a_ValidW !== 1'b0 || a_Occupancy !== 2'd0) begin errors++;
      $display("FAIL stream_drain got v=%0b occ=%0d want 0 0", a_ValidW, a_Occupancy); end
    checks++; if (a_ALUResultW !== 32'h13) begin errors++; $display("FAIL stream_hold got %0h want 13", a_ALUResultW); end
  endtask

  task automatic test_backpressure();
    a_ReadyW = 1'b0;
    a_drive(1'b1, 5'd5, 32'h55); step();
    checks++; if (a_Occupancy !== 2'd1 || a_RdW !== 5'd5 || a_ReadyM !== 1'b1) begin errors++;
      $display("FAIL bp_first got occ=%0d rd=%0d rdym=%0b want 1 5 1", a_Occupancy, a_RdW, a_ReadyM); end
    checks++; if (a_RegWriteW !== 1'b1) begin errors++; $display("FAIL bp_regwrite got %0b want 1", a_RegWriteW); end
    a_drive(1'b1, 5'd6, 32'h66); step();
    checks++; if (a_Occupancy !== 2'd2 || a_ReadyM !== 1'b0 || a_RdW !== 5'd5) begin errors++;
      $display("FAIL bp_full got occ=%0d rdym=%0b rd=%0d want 2 0 5", a_Occupancy, a_ReadyM, a_RdW); end
    a_drive(1'b1, 5'd7, 32'h77); step();
    checks++; if (a_Occupancy !== 2'd2 || a_RdW !== 5'd5 || a_ALUResultW !== 32'h55) begin errors++;
      $display("FAIL bp_stall got occ=%0d rd=%0d alu=%0h want 2 5 55", a_Occupancy, a_RdW, a_ALUResultW); end
    a_ReadyW = 1'b1; step();
    checks++; if (a_RdW !== 5'd6 || a_Occupancy !== 2'd1 || a_ReadyM !== 1'b1) begin errors++;
      $display("FAIL bp_pop1 got rd=%0d occ=%0d rdym=%0b want 6 1 1", a_RdW, a_Occupancy, a_ReadyM); end
    step();
    checks++; if (a_RdW !== 5'd7 || a_ALUResultW !== 32'h77 || a_Occupancy !== 2'd1) begin errors++;
      $display("FAIL bp_pop2 got rd=%0d alu=%0h occ=%0d want 7 77 1", a_RdW, a_ALUResultW, a_Occupancy); end
    a_drive(1'b0, 5'd0, 32'd0); step();
    checks++; if (a_ValidW !== 1'b0 || a_Occupancy !== 2'd0) begin errors++;
      $display("FAIL bp_drain got v=%0b occ=%0d want 0 0", a_ValidW, a_Occupancy); end
  endtask

  task automatic test_x0();
    a_ReadyW = 1'b1;
    a_drive(1'b1, 5'd0, 32'hDEADBEEF); step();
    checks++; if (a_ValidW !== 1'b1 || a_RegWriteW !== 1'b0 || a_ALUResultW !== 32'hDEADBEEF) begin errors++;
      $display("FAIL x0 got v=%0b rw=%0b alu=%0h want 1 0 deadbeef", a_ValidW, a_RegWriteW, a_ALUResultW); end
    a_drive(1'b0, 5'd0, 32'd0); step();
    checks++; if (a_RegWriteW !== 1'b0 || a_ValidW !== 1'b0) begin errors++;
      $display("FAIL x0_idle got rw=%0b v=%0b want 0 0", a_RegWriteW, a_ValidW); end
  endtask

  task automatic test_flush();
    a_ReadyW = 1'b0;
    a_drive(1'b1, 5'd8, 32'h88); step();
    a_drive(1'b1, 5'd9, 32'h99); step();
    checks++; if (a_Occupancy !== 2'd2) begin errors++; $display("FAIL fl_fill got %0d want 2", a_Occupancy); end
    a_FlushW = 1'b1; a_ReadyW = 1'b1;
    a_drive(1'b1, 5'd10, 32'hAA); step();
    checks++; if (a_ValidW !== 1'b0 || a_Occupancy !== 2'd0 || a_ReadyM !== 1'b1 || a_FlushCnt !== 8'd1) begin errors++;
      $display("FAIL flush got v=%0b occ=%0d rdym=%0b cnt=%0d want 0 0 1 1", a_ValidW, a_Occupancy, a_ReadyM, a_FlushCnt); end
    a_drive(1'b0, 5'd0, 32'd0); step();
    checks++; if (a_FlushCnt !== 8'd1 || a_ValidW !== 1'b0) begin errors++;
      $display("FAIL flush_empty got cnt=%0d v=%0b want 1 0", a_FlushCnt, a_ValidW); end
    a_FlushW = 1'b0;
  endtask

  task automatic test_async_reset();
    a_ReadyW = 1'b0;
    a_drive(1'b1, 5'd11, 32'hB1); step();
    a_drive(1'b1, 5'd12, 32'hC2); step();
    a_drive(1'b0, 5'd0, 32'd0);
    checks++; if (a_Occupancy !== 2'd2) begin errors++; $display("FAIL ar_fill got %0d want 2", a_Occupancy); end
    #2 RST_N = 1'b0; #1;
    checks++; if (a_ValidW !== 1'b0 || a_Occupancy !== 2'd0 || a_FlushCnt !== 8'd0 || a_RegWriteW !== 1'b0) begin errors++;
      $display("FAIL async_rst got v=%0b occ=%0d cnt=%0d rw=%0b want 0 0 0 0", a_ValidW, a_Occupancy, a_FlushCnt, a_RegWriteW); end
    checks++; if (a_ALUResultW !== 32'd0 || a_RdW !== 5'd0 || a_ReadyM !== 1'b0) begin errors++;
      $display("FAIL async_rst_pl got alu=%0h rd=%0d rdym=%0b want 0 0 0", a_ALUResultW, a_RdW, a_ReadyM); end
    #2 RST_N = 1'b1;
    a_ReadyW = 1'b1;
    a_drive(1'b1, 5'd3, 32'h33); step();
    checks++; if (a_ValidW !== 1'b1 || a_RdW !== 5'd3 || a_Occupancy !== 2'd1) begin errors++;
      $display("FAIL ar_first got v=%0b rd=%0d occ=%0d want 1 3 1", a_ValidW, a_RdW, a_Occupancy); end
    a_drive(1'b0, 5'd0, 32'd0); step();
  endtask

  task automatic test_noskid();
    b_ReadyW = 1'b0; b_ValidM = 1'b1; b_RdM = 5'd1; b_ALUResultM = 32'h11; b_RegWriteM = 1'b1;
    step();
    checks++; if (b_ValidW !== 1'b1 || b_RdW !== 5'd1 || b_ReadyM !== 1'b0) begin errors++;
      $display("FAIL ns_full got v=%0b rd=%0d rdym=%0b want 1 1 0", b_ValidW, b_RdW, b_ReadyM); end
    b_RdM = 5'd2; b_ALUResultM = 32'h22; step();
    checks++; if (b_RdW !== 5'd1 || b_Occupancy !== 2'd1) begin errors++;
      $display("FAIL ns_stall got rd=%0d occ=%0d want 1 1", b_RdW, b_Occupancy); end
    b_ReadyW = 1'b1; #1;
    checks++; if (b_ReadyM !== 1'b1) begin errors++; $display("FAIL ns_comb_ready got %0b want 1", b_ReadyM); end
    step();
    checks++; if (b_RdW !== 5'd2 || b_ALUResultW !== 32'h22 || b_Occupancy !== 2'd1) begin errors++;
      $display("FAIL ns_pass got rd=%0d alu=%0h occ=%0d want 2 22 1", b_RdW, b_ALUResultW, b_Occupancy); end
    b_ValidM = 1'b0; step();
    for (int i = 1; i <= 300; i++) begin
      b_ValidM = 1'b1; b_FlushW = 1'b0; step();
      b_ValidM = 1'b0; b_FlushW = 1'b1; step();
      if (i == 100) begin
        checks++; if (b_FlushCnt !== 8'd100) begin errors++; $display("FAIL ns_cnt100 got %0d want 100", b_FlushCnt); end
      end
      if (i == 254) begin
        checks++; if (b_FlushCnt !== 8'd254) begin errors++; $display("FAIL ns_cnt254 got %0d want 254", b_FlushCnt); end
      end
    end
    b_FlushW = 1'b0;
    checks++; if (b_FlushCnt !== 8'd255 || b_ValidW !== 1'b0) begin errors++;
      $display("FAIL ns_saturate got cnt=%0d v=%0b want 255 0", b_FlushCnt, b_ValidW); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_x0();
    test_flush();
    test_async_reset();
    test_noskid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
